// File: rtl/small_fifo_fwft_pkg.sv
// Shared definitions for small_fifo_fwft: error-counter width and saturating increment.
// The optional error counters are enabled by defining SMALL_FIFO_ERR_CNT_EN (undefined by default).
package small_fifo_fwft_pkg;

  localparam int ERR_CNT_W = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/small_fifo_ram.sv
// WIDTH x 2**ADDR_BITS storage array: synchronous write port, asynchronous read port.
module small_fifo_ram
  import small_fifo_fwft_pkg::*;
#(
  parameter int WIDTH     = 72,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] r_mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Combinational read gives first-word-fall-through on the head pointer.
  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/small_fifo_fwft.sv
// First-word-fall-through FIFO with occupancy count, programmable flags and sticky error flags.
// Define SMALL_FIFO_ERR_CNT_EN to build the saturating dropped-write / ignored-read counters.
module small_fifo_fwft
  import small_fifo_fwft_pkg::*;
#(
  parameter int WIDTH                = 72,
  parameter int MAX_DEPTH_BITS       = 3,
  parameter int PROG_FULL_THRESHOLD  = 2**MAX_DEPTH_BITS - 1,
  parameter int PROG_EMPTY_THRESHOLD = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          din,
  input  logic                      wr_en,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          dout,
  output logic                      full,
  output logic                      nearly_full,
  output logic                      prog_full,
  output logic                      empty,
  output logic                      prog_empty,
  output logic [MAX_DEPTH_BITS:0]   count,
  output logic                      overflow,
  output logic                      underflow,
  output logic [ERR_CNT_W-1:0]      ovf_cnt,
  output logic [ERR_CNT_W-1:0]      udf_cnt
);

  localparam int CW = MAX_DEPTH_BITS + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(2**MAX_DEPTH_BITS);
  localparam logic [CW-1:0] PF_C    = CW'(PROG_FULL_THRESHOLD);
  localparam logic [CW-1:0] PE_C    = CW'(PROG_EMPTY_THRESHOLD);

  logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
  logic [CW-1:0]             r_count;
  logic                      r_overflow;
  logic                      r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;
  logic w_wr_drop;
  logic w_rd_ign;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);

  // Handshake: wr_en is a write request taken when not full, or when full together with a pop
  // (the new word lands in the slot being freed); rd_en pops the head word shown on dout and is
  // taken only when not empty. Requests that are not taken are dropped and flagged, never held.
  assign w_wr_acc  = wr_en & (~w_full | rd_en);
  assign w_rd_acc  = rd_en & ~w_empty;
  assign w_wr_drop = wr_en & w_full & ~rd_en;
  assign w_rd_ign  = rd_en & w_empty;

  small_fifo_ram #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (MAX_DEPTH_BITS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_wr_acc),
    .wr_addr (r_wr_ptr),
    .wr_data (din),
    .rd_addr (r_rd_ptr),
    .rd_data (dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_wr_drop) r_overflow  <= 1'b1;
      if (w_rd_ign)  r_underflow <= 1'b1;
    end
  end

  assign full        = w_full;
  assign empty       = w_empty;
  assign nearly_full = (r_count >= (DEPTH_C - 1'b1));
  assign prog_full   = (r_count >= PF_C);
  assign prog_empty  = (r_count <= PE_C);
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

`ifdef SMALL_FIFO_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_ovf_cnt;
  logic [ERR_CNT_W-1:0] r_udf_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_cnt <= '0;
      r_udf_cnt <= '0;
    end else begin
      if (w_wr_drop) r_ovf_cnt <= sat_inc(r_ovf_cnt);
      if (w_rd_ign)  r_udf_cnt <= sat_inc(r_udf_cnt);
    end
  end

  assign ovf_cnt = r_ovf_cnt;
  assign udf_cnt = r_udf_cnt;
`else
  assign ovf_cnt = '0;
  assign udf_cnt = '0;
`endif

endmodule

// File: tb/tb_small_fifo_fwft.sv
// Self-checking bench for small_fifo_fwft (WIDTH=8, MAX_DEPTH_BITS=3): vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_small_fifo_fwft;

  localparam int W     = 8;
  localparam int DB    = 3;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] dout;
  logic         full, nearly_full, prog_full, empty, prog_empty;
  logic [DB:0]  count;
  logic         overflow, underflow;
  logic [15:0]  ovf_cnt, udf_cnt;

  always #5 clk = ~clk;

  small_fifo_fwft #(
    .WIDTH          (W),
    .MAX_DEPTH_BITS (DB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .dout        (dout),
    .full        (full),
    .nearly_full (nearly_full),
    .prog_full   (prog_full),
    .empty       (empty),
    .prog_empty  (prog_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .ovf_cnt     (ovf_cnt),
    .udf_cnt     (udf_cnt)
  );

  // ---------------- scoreboard / reference model ----------------
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_q[$];
  bit           m_ovf, m_udf;
  int           m_ovf_n, m_udf_n, m_pops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
    logic [15:0] r;
    r = '0;
`ifdef SMALL_FIFO_ERR_CNT_EN
    r = (n > 65535) ? 16'hFFFF : 16'(n);
`endif
    return r;
  endfunction

  task automatic check_model(input string tag);
    int n;
    n = exp_q.size();
    check({tag, ".count"},       32'(count),       32'(n));
    check({tag, ".empty"},       32'(empty),       32'(n == 0));
    check({tag, ".full"},        32'(full),        32'(n == DEPTH));
    check({tag, ".nearly_full"}, 32'(nearly_full), 32'(n >= DEPTH - 1));
    check({tag, ".prog_full"},   32'(prog_full),   32'(n >= DEPTH - 1));
    check({tag, ".prog_empty"},  32'(prog_empty),  32'(n <= 1));
    check({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
    check({tag, ".underflow"},   32'(underflow),   32'(m_udf));
    check({tag, ".ovf_cnt"},     32'(ovf_cnt),     32'(exp_cnt(m_ovf_n)));
    check({tag, ".udf_cnt"},     32'(udf_cnt),     32'(exp_cnt(m_udf_n)));
    if (n > 0) check({tag, ".dout"}, 32'(dout), 32'(exp_q[0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit w, input bit r, input logic [W-1:0] d, input string tag);
    bit f, e, wacc, racc;
    wr_en = w;
    rd_en = r;
    din   = d;
    f     = (exp_q.size() == DEPTH);
    e     = (exp_q.size() == 0);
    wacc  = w && (!f || r);
    racc  = r && !e;
    @(posedge clk);
    #1;
    if (racc) begin
      void'(exp_q.pop_front());
      m_pops++;
    end
    if (wacc) exp_q.push_back(d);
    if (w && f && !r) begin m_ovf = 1'b1; m_ovf_n++; end
    if (r && e)       begin m_udf = 1'b1; m_udf_n++; end
    wr_en = 1'b0;
    rd_en = 1'b0;
    check_model(tag);
  endtask

  task automatic do_reset(input bit w, input string tag);
    reset = 1'b1;
    wr_en = w;
    rd_en = 1'b0;
    din   = 8'hEE;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr_en = 1'b0;
    exp_q.delete();
    m_ovf = 0; m_udf = 0; m_ovf_n = 0; m_udf_n = 0;
    check_model(tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] din;
    logic [3:0] cnt;
    bit         emp;
    bit         ful;
    bit         nf;
    bit         pf;
    bit         pe;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit wr, bit rd, logic [7:0] d, logic [3:0] c, bit emp, bit ful,
                              bit nf, bit pf, bit pe, logic [7:0] dq);
    vec_t v;
    v.wr = wr; v.rd = rd; v.din = d; v.cnt = c; v.emp = emp; v.ful = ful;
    v.nf = nf; v.pf = pf; v.pe = pe; v.dout = dq;
    vecs.push_back(v);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    //            wr rd din    cnt emp ful nf pf pe dout
    add(1, 0, 8'h11, 4'd1, 0, 0, 0, 0, 1, 8'h11);
    add(1, 0, 8'h22, 4'd2, 0, 0, 0, 0, 0, 8'h11);
    add(1, 0, 8'h33, 4'd3, 0, 0, 0, 0, 0, 8'h11);
    add(0, 1, 8'h00, 4'd2, 0, 0, 0, 0, 0, 8'h22);
    add(0, 1, 8'h00, 4'd1, 0, 0, 0, 0, 1, 8'h33);
    add(0, 1, 8'h00, 4'd0, 1, 0, 0, 0, 1, 8'h00);
    add(1, 0, 8'h40, 4'd1, 0, 0, 0, 0, 1, 8'h40);
    add(1, 0, 8'h41, 4'd2, 0, 0, 0, 0, 0, 8'h40);
    add(1, 0, 8'h42, 4'd3, 0, 0, 0, 0, 0, 8'h40);
    add(1, 0, 8'h43, 4'd4, 0, 0, 0, 0, 0, 8'h40);
    add(1, 0, 8'h44, 4'd5, 0, 0, 0, 0, 0, 8'h40);
    add(1, 0, 8'h45, 4'd6, 0, 0, 0, 0, 0, 8'h40);
    add(1, 0, 8'h46, 4'd7, 0, 0, 1, 1, 0, 8'h40);
    add(1, 0, 8'h47, 4'd8, 0, 1, 1, 1, 0, 8'h40);
    add(1, 0, 8'h48, 4'd8, 0, 1, 1, 1, 0, 8'h40);

    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    m_ovf = 0; m_udf = 0; m_ovf_n = 0; m_udf_n = 0; m_pops = 0;
    #1;
    do_reset(1'b0, "rst0");

    // Test 1/2: write latency, pop order, fill, flags, dropped ninth write
    wr_en = 1'b1; din = 8'h11;
    #2;
    check("t1.empty_before_edge", 32'(empty), 32'd1);
    foreach (vecs[i]) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].din, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.cnt", i),  32'(count),       32'(vecs[i].cnt));
      check($sformatf("vec%0d.emp", i),  32'(empty),       32'(vecs[i].emp));
      check($sformatf("vec%0d.ful", i),  32'(full),        32'(vecs[i].ful));
      check($sformatf("vec%0d.nf", i),   32'(nearly_full), 32'(vecs[i].nf));
      check($sformatf("vec%0d.pf", i),   32'(prog_full),   32'(vecs[i].pf));
      check($sformatf("vec%0d.pe", i),   32'(prog_empty),  32'(vecs[i].pe));
      if (!vecs[i].emp) check($sformatf("vec%0d.dout", i), 32'(dout), 32'(vecs[i].dout));
    end
    check("t2.overflow", 32'(overflow), 32'd1);
    check("t2.ovf_cnt",  32'(ovf_cnt),  32'(exp_cnt(1)));

    // Test 3: simultaneous push/pop while full
    for (int i = 0; i < 8; i++) begin
      check("t3.pop_order", 32'(dout), 32'(8'h40 + i));
      step(1'b1, 1'b1, 8'hAA, "t3.both");
      check("t3.count_full", 32'(count), 32'd8);
    end
    for (int i = 0; i < 8; i++) begin
      check("t3.new_word", 32'(dout), 32'hAA);
      step(1'b0, 1'b1, 8'h00, "t3.drain");
    end
    check("t3.empty", 32'(empty), 32'd1);

    // Test 4: reads on empty, then push+pop on empty
    do_reset(1'b0, "rst4");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, "t4.udf");
    check("t4.underflow", 32'(underflow), 32'd1);
    check("t4.udf_cnt",   32'(udf_cnt),   32'(exp_cnt(3)));
    check("t4.count0",    32'(count),     32'd0);
    step(1'b1, 1'b1, 8'h5C, "t4.both_empty");
    check("t4.count1", 32'(count), 32'd1);
    check("t4.dout",   32'(dout),  32'h5C);

    // Test 5: random traffic across pointer wrap
    do_reset(1'b0, "rst5");
    m_pops = 0;
    guard  = 0;
    while ((m_pops < 40 || exp_q.size() != 0) && guard < 2000) begin
      bit w, r;
      w = ($urandom_range(0, 99) < ((m_pops < 40) ? 60 : 0));
      r = ($urandom_range(0, 99) < 50);
      step(w, r, W'($urandom_range(0, 255)), "t5.rand");
      guard++;
    end
    check("t5.words_popped", 32'(m_pops >= 40), 32'd1);
    check("t5.drained",      32'(empty),        32'd1);

    // Test 6: reset mid-burst with errors set and wr_en high
    do_reset(1'b0, "rst6a");
    step(1'b0, 1'b1, 8'h00, "t6.udf");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, W'(8'h60 + i), "t6.fill");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, "t6.pop");
    check("t6.count5", 32'(count), 32'd5);
    do_reset(1'b1, "t6.reset");
    check("t6.count0",    32'(count),     32'd0);
    check("t6.empty",     32'(empty),     32'd1);
    check("t6.overflow",  32'(overflow),  32'd0);
    check("t6.underflow", 32'(underflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
